// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter sharing one 4-bit magnitude comparator among NREQ requesters.
// Stage 0 grants and captures operands; stage 1 registers the tagged compare result.

module comparator_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       lt,
  output logic       eq,
  output logic       gt
);
  assign lt = (a < b);
  assign eq = (a == b);
  assign gt = (a > b);
endmodule

module cmp_share_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] a_bus,
  input  logic [4*NREQ-1:0] b_bus,
  output logic [NREQ-1:0]   gnt,
  output logic              res_valid,
  output logic [IDW-1:0]    res_id,
  output logic              lt,
  output logic              eq,
  output logic              gt
);

  localparam int unsigned OPW = 4;

  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [OPW-1:0]  opa_q, opa_d, opb_q, opb_d;
  logic            s1_v_q, s1_v_d;
  logic [IDW-1:0]  s1_id_q, s1_id_d;
  logic            res_valid_q, res_valid_d;
  logic [IDW-1:0]  res_id_q, res_id_d;
  logic            lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;

  logic [NREQ-1:0] elig_c;
  logic            found_c;
  logic [IDW-1:0]  win_c;
  logic            cmp_lt, cmp_eq, cmp_gt;

  comparator_4bit u_cmp (
    .a  (opa_q),
    .b  (opb_q),
    .lt (cmp_lt),
    .eq (cmp_eq),
    .gt (cmp_gt)
  );

  // Winner: lowest eligible index >= ptr, else lowest eligible index overall (wrap).
  always_comb begin
    elig_c  = req & ~gnt_q;
    found_c = 1'b0;
    win_c   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (elig_c[i]) begin
        found_c = 1'b1;
        win_c   = IDW'(i);
      end
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (elig_c[i] && (IDW'(i) >= ptr_q)) begin
        win_c = IDW'(i);
      end
    end
  end

  always_comb begin
    gnt_d       = '0;
    ptr_d       = ptr_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    s1_v_d      = found_c;
    s1_id_d     = s1_id_q;
    res_valid_d = s1_v_q;
    res_id_d    = s1_id_q;
    lt_d        = lt_q;
    eq_d        = eq_q;
    gt_d        = gt_q;

    for (int i = 0; i < NREQ; i++) begin
      if (found_c && (win_c == IDW'(i))) begin
        gnt_d[i] = 1'b1;
        opa_d    = a_bus[OPW*i +: OPW];
        opb_d    = b_bus[OPW*i +: OPW];
      end
    end

    if (found_c) begin
      s1_id_d = win_c;
      ptr_d   = (win_c == IDW'(NREQ - 1)) ? '0 : win_c + IDW'(1);
    end

    // Flags hold their last value across idle cycles.
    if (s1_v_q) begin
      lt_d = cmp_lt;
      eq_d = cmp_eq;
      gt_d = cmp_gt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q       <= '0;
      ptr_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      s1_v_q      <= 1'b0;
      s1_id_q     <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      lt_q        <= 1'b0;
      eq_q        <= 1'b0;
      gt_q        <= 1'b0;
    end else begin
      gnt_q       <= gnt_d;
      ptr_q       <= ptr_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      s1_v_q      <= s1_v_d;
      s1_id_q     <= s1_id_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      lt_q        <= lt_d;
      eq_q        <= eq_d;
      gt_q        <= gt_d;
    end
  end

  assign gnt       = gnt_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign lt        = lt_q;
  assign eq        = eq_q;
  assign gt        = gt_q;

endmodule

// File: doc/cmp_share_arbiter.md
Name: cmp_share_arbiter

Overview:
- Shares one 4-bit magnitude comparator datapath (comparator_4bit, ports a, b, lt, eq, gt) among NREQ requesters.
- Round-robin arbitration with a req/gnt handshake; at most one comparison is issued per cycle.
- The result is registered and returned tagged with the requester index.
- Sits between client blocks needing occasional 4-bit magnitude compares and a single comparator instance, instantiated inside this block.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of res_id. Must be at least clog2(NREQ); checked by the bench.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  NREQ  per-requester request, level
- a_bus  input  4*NREQ  operand A; requester i uses bits [4i+3:4i]
- b_bus  input  4*NREQ  operand B; same packing as a_bus
- gnt  output  NREQ  one-hot grant pulse, registered
- res_valid  output  1  result valid pulse, registered
- res_id  output  IDW  index of requester owning the result
- lt  output  1  A < B (unsigned), valid when res_valid=1
- eq  output  1  A == B
- gt  output  1  A > B

Behaviour:
- Clock and reset: single clock domain clk. Reset is asynchronous and active-low on rst_n; assertion clears state immediately, independent of clk.
- Reset values: gnt=0, res_valid=0, res_id=0, lt=0, eq=0, gt=0, round-robin pointer ptr=0, operand registers opa=0 and opb=0, stage-1 valid s1_v=0, s1_id=0.
- Stage 0, arbitration:
  - At each rising edge, eligible = req & ~gnt. Masking the currently granted requester prevents a double grant while it drops req.
  - If eligible is nonzero, the winner is the first set bit scanning upward from ptr, wrapping modulo NREQ.
  - On a win: gnt <= onehot(winner); opa/opb <= that requester's slices of a_bus/b_bus; s1_v <= 1; s1_id <= winner; ptr <= (winner+1) mod NREQ.
  - If eligible is zero: gnt <= 0, s1_v <= 0, ptr unchanged.
- Stage 1, compare: comparator_4bit is driven combinationally from opa/opb. At the next edge: res_valid <= s1_v; res_id <= s1_id; lt/eq/gt <= comparator outputs when s1_v=1, else hold their previous values.
- Latency: req sampled high at edge E gives gnt high during cycle E..E+1, and res_valid high during E+1..E+2.
- Throughput: one grant and one result per cycle with back-to-back requesters.
- Handshake:
  - Requester holds req and its operands stable until it sees gnt=1.
  - It deasserts req or changes operands only after that edge.
  - A requester may re-request immediately (req high again the cycle after gnt); it competes normally, and the round-robin places it last.
- Exclusivity: exactly one of lt/eq/gt is 1 whenever res_valid=1. gnt is one-hot or zero, never multi-hot.
- Boundary conditions:
  - Single requester held continuously: granted every other cycle because of the gnt mask.
  - All requesters active: grants rotate 0,1,2,3,0...
  - ptr wrap from NREQ-1 to 0.
  - Operand extremes 0000/1111 compare unsigned.
  - rst_n asserted mid-operation aborts in-flight compares with no res_valid. After deassertion the first grant scans from index 0.

Test Plan:
- Reset: rst_n=0 mid-stream, with s1_v=1 and gnt high, so an operation is in flight → gnt, res_valid, lt/eq/gt all 0 immediately (async, before the next clk edge); after release, req=4'b1000 → gnt=4'b1000 one cycle later.
- Single request: req=4'b0001, a0=0010, b0=1001 → gnt=0001 for 1 cycle; next cycle res_valid=1, res_id=0, lt=1, eq=0, gt=0.
- Full contention: req=4'b1111 held, operands per requester (1110 vs 1001), (0000 vs 0000), (1010 vs 1010), (1101 vs 1001) → grants 0,1,2,3,0 in consecutive cycles; results gt, eq, eq, gt with res_id 0,1,2,3.
- Fairness/wrap: after grant to 3, req=4'b1001 → next grant to 0 then 3; ptr wraps correctly.
- Extremes and hold: a=1111, b=0000 → gt=1; a=0000, b=1111 → lt=1; then idle cycles → res_valid=0 and lt/eq/gt hold their last values.
- Held req without drop: req=4'b0100 kept high → gnt=0100 on alternating cycles only; each result matches the operands current at its grant edge.
